// File: rtl/digit_serial_subtractor.sv
// Digit-serial a + ~b + cin over WIDTH bits, DIGIT bits per clock, with an optional
// magnitude pass. Define DSSUB_OVF_EN to compute the signed-overflow flag; otherwise ovf is 0.
module digit_serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ge,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SUB, CORR, DONE} state_t;

  // Handshake: a transfer happens on a rising edge where valid && ready; operands are
  // taken only on that edge, and result/ge/ovf hold steady while out_valid waits.
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_r, b_r, res_r;
  logic            mode_r, carry, ge_r;
  logic [DIGIT-1:0] a_d, b_d, r_d, op_x, op_y;
  logic [DIGIT:0]  sum;
  logic            last;

  // One shared slice: SUB adds a + ~b, CORR adds ~r + 0 with carry seeded to 1.
  always_comb begin
    a_d  = a_r[cnt*DIGIT +: DIGIT];
    b_d  = b_r[cnt*DIGIT +: DIGIT];
    r_d  = res_r[cnt*DIGIT +: DIGIT];
    op_x = (state == CORR) ? ~r_d : a_d;
    op_y = (state == CORR) ? '0 : ~b_d;
    sum  = {1'b0, op_x} + {1'b0, op_y} + {{DIGIT{1'b0}}, carry};
    last = (cnt == CW'(N - 1));
  end

`ifdef DSSUB_OVF_EN
  logic ovf_r;
  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_r;
  assign ge        = ge_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      res_r  <= '0;
      mode_r <= 1'b0;
      carry  <= 1'b0;
      ge_r   <= 1'b0;
`ifdef DSSUB_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            mode_r <= mode;
            carry  <= cin;
            cnt    <= '0;
            state  <= SUB;
          end
        end
        SUB: begin
          res_r[cnt*DIGIT +: DIGIT] <= sum[DIGIT-1:0];
          carry <= sum[DIGIT];
          cnt   <= cnt + CW'(1);
          if (last) begin
            ge_r <= sum[DIGIT];
`ifdef DSSUB_OVF_EN
            ovf_r <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sum[DIGIT-1] != a_r[WIDTH-1]);
`endif
            cnt <= '0;
            if (mode_r && !sum[DIGIT]) begin
              carry <= 1'b1;
              state <= CORR;
            end else begin
              state <= DONE;
            end
          end
        end
        CORR: begin
          res_r[cnt*DIGIT +: DIGIT] <= sum[DIGIT-1:0];
          carry <= sum[DIGIT];
          cnt   <= cnt + CW'(1);
          if (last) begin
            cnt   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Directed bench for digit_serial_subtractor (WIDTH=16, DIGIT=4): driver pushes expected
// {ovf, ge, result} and first-valid edge into queues; a negedge monitor checks them.
module tb_digit_serial_subtractor;
  localparam int W = 16;
  localparam int N = 4;
`ifdef DSSUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, cin, mode, out_valid, out_ready, ge, ovf;
  logic [W-1:0] a, b, result;

  logic [W+1:0] exp_q[$];
  int           t_q[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  bit           prev_v = 1'b0;

  digit_serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .ge(ge), .ovf(ovf)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("result_ge_ovf", 32'({ovf, ge, result}), 32'(exp_q[0]));
          if (!prev_v) chk("latency", 32'(cyc), 32'(t_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(t_q.pop_front());
          end
        end
      end
      prev_v = out_valid;
    end
  end

  // driver: called at #1 after a rising edge, returns likewise
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                        input logic tmode, input logic [W-1:0] eres, input logic ege,
                        input logic eovf, input int lat, input int hold);
    bit seen = 1'b0;
    a = ta; b = tb_v; cin = tcin; mode = tmode; in_valid = 1'b1;
    out_ready = (hold == 0);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); mode = 1'($urandom);
    exp_q.push_back({eovf & OVF_EN, ege, eres});
    t_q.push_back(cyc + lat);
    for (int i = 0; i < 64; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL timeout: out_valid never rose (cycle %0d)", cyc);
      return;
    end
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
      end
      chk("out_valid_held", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; mode = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_outputs", 32'({out_valid, ovf, ge, result}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    run_op(16'h0009, 16'h0009, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, N,     0);
    run_op(16'h000D, 16'h0009, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b0, N,     0);
    run_op(16'h0007, 16'h000D, 1'b1, 1'b0, 16'hFFFA, 1'b0, 1'b0, N,     0);
    run_op(16'h0007, 16'h000D, 1'b1, 1'b1, 16'h0006, 1'b0, 1'b0, 2 * N, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, N,     0);
    run_op(16'h1234, 16'h0034, 1'b1, 1'b0, 16'h1200, 1'b1, 1'b0, N,     3);
    // cin=0 in magnitude mode: raw 5-5-1 = 0xFFFF, carry 0, negated to 1
    run_op(16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 2 * N, 0);
    run_op(16'h0003, 16'h8001, 1'b1, 1'b0, 16'h8002, 1'b0, 1'b1, N,     0);

    // abort mid-SUB with reset
    a = 16'h00F0; b = 16'h000F; cin = 1'b1; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_outputs", 32'({out_valid, ovf, ge, result}), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_abort", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    run_op(16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'hF1FF, 1'b0, 1'b0, N, 0);
    run_op(16'h00FF, 16'h0F00, 1'b1, 1'b1, 16'h0E01, 1'b0, 1'b0, 2 * N, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
